// File: rtl/instr_sequencer_if.sv
// Memory-side handshake bundle for the instruction sequencer.
// The master modport is the sequencer. The slave modport is the
// instruction/data memory that answers its requests.
interface instr_sequencer_if;
    logic        imem_req;
    logic        imem_ack;
    logic [23:0] imem_data;
    logic        dmem_req;
    logic        dmem_ack;

    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_data,
        output dmem_req,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_data,
        input  dmem_req,
        output dmem_ack
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer.
// The FSM walks FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK for each instruction
// until the all-ones HALT word is decoded.
// Every output is a register. The request strobes are loaded from the
// next-state value, so each one is high exactly while the FSM sits in its
// matching state.
module instr_sequencer (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    instr_sequencer_if.master         mem,
    output logic [15:0]               pc,
    output logic [23:0]               ir,
    input  logic                      branch_cond,
    input  logic [15:0]               branch_target,
    output logic                      wb_en,
    output logic                      halted,
    output logic [2:0]                state,
    output logic [15:0]               retired
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    localparam logic [23:0] HALT_WORD = 24'hFFFFFF;

    state_t cur_state;
    state_t nxt_state;
    logic   retire_now;
    logic   take_branch;
    logic   fetch_done;

    assign state      = cur_state;
    assign fetch_done = (cur_state == S_FETCH) && mem.imem_ack;

    // Next-state decode plus the retire and branch-taken decisions for this cycle.
    always_comb begin
        nxt_state   = cur_state;
        retire_now  = 1'b0;
        take_branch = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (start) nxt_state = S_FETCH;
                else       nxt_state = S_IDLE;
            end
            S_FETCH: begin
                if (mem.imem_ack) nxt_state = S_DECODE;
                else              nxt_state = S_FETCH;
            end
            S_DECODE: begin
                if (ir == HALT_WORD) begin
                    // The HALT instruction itself counts as retired.
                    nxt_state  = S_HALT;
                    retire_now = 1'b1;
                end else begin
                    nxt_state = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (ir[23:22])
                    2'b10: nxt_state = S_MEMORY;
                    2'b11: begin
                        nxt_state   = S_FETCH;
                        retire_now  = 1'b1;
                        take_branch = branch_cond;
                    end
                    default: nxt_state = S_WRITEBACK;
                endcase
            end
            S_MEMORY: begin
                if (mem.dmem_ack) begin
                    if (ir[0]) begin
                        // A store completes here and never writes back.
                        nxt_state  = S_FETCH;
                        retire_now = 1'b1;
                    end else begin
                        nxt_state = S_WRITEBACK;
                    end
                end else begin
                    nxt_state = S_MEMORY;
                end
            end
            S_WRITEBACK: begin
                nxt_state  = S_FETCH;
                retire_now = 1'b1;
            end
            S_HALT: begin
                nxt_state = S_HALT;
            end
            default: begin
                // The unused encoding recovers to IDLE.
                nxt_state = S_IDLE;
            end
        endcase
    end

    // State register, program counter, instruction latch, retire count and registered strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state    <= S_IDLE;
            pc           <= 16'd0;
            ir           <= 24'd0;
            retired      <= 16'd0;
            mem.imem_req <= 1'b0;
            mem.dmem_req <= 1'b0;
            wb_en        <= 1'b0;
            halted       <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            mem.imem_req <= (nxt_state == S_FETCH);
            mem.dmem_req <= (nxt_state == S_MEMORY);
            wb_en        <= (nxt_state == S_WRITEBACK);
            halted       <= (nxt_state == S_HALT);
            if (fetch_done) begin
                ir <= mem.imem_data;
                pc <= pc + 16'd1;
            end else if (take_branch) begin
                pc <= branch_target;
            end else begin
                pc <= pc;
            end
            if (retire_now) retired <= retired + 16'd1;
            else            retired <= retired;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer.
// The reference model tracks the planned route of states for each fetched
// instruction. Directed scenarios first pin that model with literal
// expectations. A long randomized run then follows.
module tb_instr_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pc;
    logic [23:0] ir;
    logic        branch_cond;
    logic [15:0] branch_target;
    logic        wb_en;
    logic        halted;
    logic [2:0]  state;
    logic [15:0] retired;

    instr_sequencer_if bus ();

    instr_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .mem           (bus.master),
        .pc            (pc),
        .ir            (ir),
        .branch_cond   (branch_cond),
        .branch_target (branch_target),
        .wb_en         (wb_en),
        .halted        (halted),
        .state         (state),
        .retired       (retired)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: the current phase, plus the queue of phases still
    // planned for the instruction in flight.
    // Phase codes: 0 idle, 1 fetch, 2 decode, 3 execute, 4 memory, 5 writeback, 6 halt.
    int          m_st;
    int          route[$];
    logic [15:0] m_pc;
    logic [23:0] m_ir;
    logic [15:0] m_ret;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock, using the inputs currently driven.
    task automatic model_step();
        int nxt;
        if (reset) begin
            m_st  = 0;
            m_pc  = 16'd0;
            m_ir  = 24'd0;
            m_ret = 16'd0;
            route.delete();
        end else if (m_st == 0) begin
            if (start) m_st = 1;
        end else if (m_st == 1) begin
            if (bus.imem_ack) begin
                m_ir = bus.imem_data;
                m_pc = m_pc + 16'd1;
                route.delete();
                if (m_ir == 24'hFFFFFF)           route = '{2, 6};
                else if (m_ir[23:22] == 2'b11)    route = '{2, 3, 1};
                else if (m_ir[23:22] == 2'b10)    route = m_ir[0] ? '{2, 3, 4, 1} : '{2, 3, 4, 5, 1};
                else                              route = '{2, 3, 5, 1};
                m_st = route.pop_front();
            end
        end else if (m_st == 6) begin
            m_st = 6;
        end else if (m_st == 4 && !bus.dmem_ack) begin
            m_st = 4;
        end else begin
            if (m_st == 3 && m_ir[23:22] == 2'b11 && branch_cond) m_pc = branch_target;
            nxt = route.pop_front();
            // An instruction completes when its route ends, either back in fetch or in halt.
            if (nxt == 1 || nxt == 6) m_ret = m_ret + 16'd1;
            m_st = nxt;
        end
    endtask

    // Compare every DUT output against the model.
    task automatic compare_all();
        chk("state",    {29'd0, state},          m_st);
        chk("pc",       {16'd0, pc},             {16'd0, m_pc});
        chk("ir",       {8'd0, ir},              {8'd0, m_ir});
        chk("retired",  {16'd0, retired},        {16'd0, m_ret});
        chk("imem_req", {31'd0, bus.imem_req},   (m_st == 1) ? 32'd1 : 32'd0);
        chk("dmem_req", {31'd0, bus.dmem_req},   (m_st == 4) ? 32'd1 : 32'd0);
        chk("wb_en",    {31'd0, wb_en},          (m_st == 5) ? 32'd1 : 32'd0);
        chk("halted",   {31'd0, halted},         (m_st == 6) ? 32'd1 : 32'd0);
    endtask

    // One clock: step the model, let the edge pass, then check just after it.
    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic restart();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic fetch(input logic [23:0] d);
        bus.imem_ack  = 1'b1;
        bus.imem_data = d;
        cyc();
        bus.imem_ack  = 1'b0;
    endtask

    int cnt;
    int k;

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        branch_cond   = 1'b0;
        branch_target = 16'd0;
        bus.imem_ack  = 1'b0;
        bus.imem_data = 24'd0;
        bus.dmem_ack  = 1'b0;
        m_st  = 0;
        m_pc  = 16'd0;
        m_ir  = 24'd0;
        m_ret = 16'd0;

        // Reset held for several cycles.
        cyc();
        cyc();
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_pc", {16'd0, pc}, 32'd0);
        chk("rst_req", {30'd0, bus.imem_req, bus.dmem_req}, 32'd0);

        // V1: ALU instruction with a same-cycle fetch ack.
        reset = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("v1_fetch", {29'd0, state}, 32'd1);
        fetch(24'h000010);
        chk("v1_ir", {8'd0, ir}, 32'h10);
        chk("v1_pc", {16'd0, pc}, 32'd1);
        cyc();
        cyc();
        chk("v1_wb_c4", {31'd0, wb_en}, 32'd1);
        cyc();
        chk("v1_wb_off", {31'd0, wb_en}, 32'd0);
        chk("v1_ret", {16'd0, retired}, 32'd1);
        chk("v1_refetch", {29'd0, state}, 32'd1);

        // V2: load whose data-memory ack arrives three cycles late.
        restart();
        fetch(24'h800000);
        cyc();
        cyc();
        cnt = 0;
        for (k = 0; k < 4; k++) begin
            if (bus.dmem_req) cnt++;
            bus.dmem_ack = (k == 3);
            cyc();
        end
        bus.dmem_ack = 1'b0;
        chk("v2_dreq_cycles", cnt, 32'd4);
        chk("v2_wb", {29'd0, state}, 32'd5);
        cyc();
        chk("v2_ret", {16'd0, retired}, 32'd1);

        // V3: taken branch redirects pc and never writes back.
        restart();
        fetch(24'hC01000);
        branch_cond   = 1'b1;
        branch_target = 16'h0040;
        cyc();
        chk("v3_wb_x", {31'd0, wb_en}, 32'd0);
        cyc();
        chk("v3_wb_f", {31'd0, wb_en}, 32'd0);
        chk("v3_pc", {16'd0, pc}, 32'h40);
        chk("v3_state", {29'd0, state}, 32'd1);
        branch_cond = 1'b0;

        // V4: pc wraps from FFFF to 0 on a fetch.
        restart();
        fetch(24'hC00000);
        branch_cond   = 1'b1;
        branch_target = 16'hFFFF;
        cyc();
        cyc();
        branch_cond = 1'b0;
        chk("v4_pre", {16'd0, pc}, 32'hFFFF);
        fetch(24'h000001);
        chk("v4_wrap", {16'd0, pc}, 32'd0);

        // V5: HALT is sticky, ignores start, and is left only through reset.
        restart();
        fetch(24'hFFFFFF);
        cyc();
        chk("v5_halt", {29'd0, state}, 32'd6);
        chk("v5_halted", {31'd0, halted}, 32'd1);
        chk("v5_ret", {16'd0, retired}, 32'd1);
        for (k = 0; k < 3; k++) begin
            start = 1'b1;
            cyc();
        end
        start = 1'b0;
        chk("v5_stay", {29'd0, state}, 32'd6);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("v5_idle", {29'd0, state}, 32'd0);
        chk("v5_pc", {16'd0, pc}, 32'd0);

        // V6: reset mid-MEMORY wins over a same-cycle dmem_ack.
        restart();
        fetch(24'h800001);
        cyc();
        cyc();
        chk("v6_mem", {31'd0, bus.dmem_req}, 32'd1);
        reset        = 1'b1;
        bus.dmem_ack = 1'b1;
        cyc();
        reset        = 1'b0;
        bus.dmem_ack = 1'b0;
        chk("v6_state", {29'd0, state}, 32'd0);
        chk("v6_ret", {16'd0, retired}, 32'd0);
        chk("v6_dreq", {31'd0, bus.dmem_req}, 32'd0);

        // Randomized traffic. Acks and start arrive at arbitrary times,
        // including in states where they must be ignored.
        for (int i = 0; i < 4000; i++) begin
            reset         = ($urandom_range(0, 39) == 0);
            start         = ($urandom_range(0, 3) == 0);
            bus.imem_ack  = $urandom_range(0, 1);
            bus.imem_data = ($urandom_range(0, 15) == 0) ? 24'hFFFFFF : 24'($urandom());
            bus.dmem_ack  = $urandom_range(0, 1);
            branch_cond   = $urandom_range(0, 1);
            branch_target = 16'($urandom());
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
